// File: rtl/ecliptic_fpu_dispatch_if.sv
// ecliptic_fpu_dispatch_if: bundles the core-side issue handshake, the shared
// execution-unit request/operand buses, and the writeback handshake.
// The dispatcher uses the slave modport. The environment (core, units and
// writeback) uses the master modport.
interface ecliptic_fpu_dispatch_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_UNITS = 4,
  parameter int OP_W      = 2
);
  localparam int UNIT_W = $clog2(NUM_UNITS) + 1;

  logic                       in_valid;
  logic                       in_ready;
  logic [UNIT_W-1:0]          in_unit;
  logic [OP_W-1:0]            in_op;
  logic [WIDTH-1:0]           in_src1;
  logic [WIDTH-1:0]           in_src2;
  logic [4:0]                 in_rd;
  logic [NUM_UNITS-1:0]       unit_req;
  logic [OP_W-1:0]            unit_op;
  logic [WIDTH-1:0]           unit_src1;
  logic [WIDTH-1:0]           unit_src2;
  logic [NUM_UNITS-1:0]       unit_ack;
  logic [NUM_UNITS*WIDTH-1:0] unit_res;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_res;
  logic [4:0]                 out_rd;
  logic                       out_err;

  modport slave (
    input  in_valid, in_unit, in_op, in_src1, in_src2, in_rd,
    input  unit_ack, unit_res, out_ready,
    output in_ready, unit_req, unit_op, unit_src1, unit_src2,
    output out_valid, out_res, out_rd, out_err
  );

  modport master (
    output in_valid, in_unit, in_op, in_src1, in_src2, in_rd,
    output unit_ack, unit_res, out_ready,
    input  in_ready, unit_req, unit_op, unit_src1, unit_src2,
    input  out_valid, out_res, out_rd, out_err
  );
endinterface

// File: rtl/ecliptic_fpu_dispatch.sv
// ecliptic_fpu_dispatch: single-issue dispatcher in front of the FPU units.
// It accepts one operation, requests the selected unit until that unit acks,
// and then holds the result for writeback. Only one operation is in flight.
// Optional feature macro: ECLIPTIC_FPU_DISPATCH_TIMEOUT_EN. When defined, a
// watchdog ends a WAIT that runs TIMEOUT_CYCLES cycles with out_err=1.
module ecliptic_fpu_dispatch #(
  parameter int WIDTH          = 32,
  parameter int NUM_UNITS      = 4,
  parameter int OP_W           = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                    clk,
  input logic                    rst,
  ecliptic_fpu_dispatch_if.slave bus
);
  localparam int UNIT_W = $clog2(NUM_UNITS) + 1;
  localparam int SEL_W  = $clog2(NUM_UNITS);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] WAIT = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [UNIT_W-1:0]    UNIT_LIMIT = UNIT_W'(NUM_UNITS);
  localparam logic [NUM_UNITS-1:0] REQ_ONE    = NUM_UNITS'(1);

  logic [1:0]           state;
  logic [SEL_W-1:0]     sel;
  logic [NUM_UNITS-1:0] req;
  logic [OP_W-1:0]      op;
  logic [WIDTH-1:0]     src1;
  logic [WIDTH-1:0]     src2;
  logic [WIDTH-1:0]     res;
  logic [4:0]           rd;
  logic                 err;
  logic                 unit_ok;
  logic                 ack_hit;
  logic [WIDTH-1:0]     res_pick;
  logic                 timeout_hit;

  assign unit_ok = (bus.in_unit < UNIT_LIMIT);

  // Pick the ack and result of the selected unit. Acks from other units never reach the FSM.
  always_comb begin
    ack_hit  = bus.unit_ack[sel];
    res_pick = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (sel == SEL_W'(k)) begin
        res_pick = bus.unit_res[k*WIDTH +: WIDTH];
      end else begin
        res_pick = res_pick;
      end
    end
  end

`ifdef ECLIPTIC_FPU_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  // The watchdog fires on the TIMEOUT_CYCLES-th consecutive WAIT cycle without an ack.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count WAIT cycles. The counter is held at zero outside WAIT, so every entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= {CNT_W{1'b0}};
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= {CNT_W{1'b0}};
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Dispatch FSM: accept an operation, wait for the unit ack (or the watchdog), then hold the result until writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= {SEL_W{1'b0}};
      req   <= {NUM_UNITS{1'b0}};
      op    <= {OP_W{1'b0}};
      src1  <= {WIDTH{1'b0}};
      src2  <= {WIDTH{1'b0}};
      res   <= {WIDTH{1'b0}};
      rd    <= 5'd0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op   <= bus.in_op;
            src1 <= bus.in_src1;
            src2 <= bus.in_src2;
            rd   <= bus.in_rd;
            sel  <= bus.in_unit[SEL_W-1:0];
            if (unit_ok) begin
              state <= WAIT;
              req   <= REQ_ONE << bus.in_unit[SEL_W-1:0];
              err   <= 1'b0;
            end else begin
              state <= DONE;
              res   <= {WIDTH{1'b0}};
              err   <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (ack_hit) begin
            state <= DONE;
            req   <= {NUM_UNITS{1'b0}};
            res   <= res_pick;
            err   <= 1'b0;
          end else if (timeout_hit) begin
            state <= DONE;
            req   <= {NUM_UNITS{1'b0}};
            res   <= {WIDTH{1'b0}};
            err   <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          req   <= {NUM_UNITS{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.unit_req  = req;
  assign bus.unit_op   = op;
  assign bus.unit_src1 = src1;
  assign bus.unit_src2 = src2;
  assign bus.out_res   = res;
  assign bus.out_rd    = rd;
  assign bus.out_err   = err;
endmodule

// File: tb/tb_ecliptic_fpu_dispatch.sv
// tb_ecliptic_fpu_dispatch: directed bench for ecliptic_fpu_dispatch.
// A transaction-level reference model runs alongside the DUT and is compared
// on every negedge. Each scenario also has hand-computed literal checks.
module tb_ecliptic_fpu_dispatch;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int OPW = 2;
  localparam int TMO = 16;
`ifdef ECLIPTIC_FPU_DISPATCH_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ecliptic_fpu_dispatch_if #(.WIDTH(W), .NUM_UNITS(N), .OP_W(OPW)) bus ();

  ecliptic_fpu_dispatch #(
    .WIDTH(W), .NUM_UNITS(N), .OP_W(OPW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model, kept at transaction level: is an op in flight, is it waiting, is a result ready.
  bit             m_busy, m_wait, m_have, m_err;
  int             m_sel, m_cnt;
  logic [W-1:0]   m_res, m_s1, m_s2;
  logic [OPW-1:0] m_op;
  logic [4:0]     m_rd;

  // Advance the model from the inputs sampled at each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_wait <= 1'b0; m_have <= 1'b0; m_err <= 1'b0;
      m_sel <= 0; m_cnt <= 0; m_res <= '0; m_s1 <= '0; m_s2 <= '0;
      m_op <= '0; m_rd <= '0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        m_busy <= 1'b1;
        m_op <= bus.in_op; m_s1 <= bus.in_src1; m_s2 <= bus.in_src2; m_rd <= bus.in_rd;
        if (int'(bus.in_unit) < N) begin
          m_wait <= 1'b1; m_sel <= int'(bus.in_unit); m_cnt <= 0;
        end else begin
          m_have <= 1'b1; m_res <= '0; m_err <= 1'b1;
        end
      end
    end else if (m_wait) begin
      if (bus.unit_ack[m_sel]) begin
        m_wait <= 1'b0; m_have <= 1'b1; m_err <= 1'b0;
        m_res <= bus.unit_res[m_sel*W +: W];
      end else if (TMO_EN && (m_cnt + 1 == TMO)) begin
        m_wait <= 1'b0; m_have <= 1'b1; m_err <= 1'b1; m_res <= '0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (m_have && bus.out_ready) begin
      m_have <= 1'b0; m_busy <= 1'b0;
    end
  end

  // Compare DUT outputs against the model every cycle outside reset.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("in_ready", bus.in_ready, !m_busy);
      check("out_valid", bus.out_valid, m_have);
      check("unit_req", bus.unit_req, m_wait ? (64'd1 << m_sel) : 64'd0);
      if (m_wait) begin
        check("unit_op", bus.unit_op, m_op);
        check("unit_src1", bus.unit_src1, m_s1);
        check("unit_src2", bus.unit_src2, m_s2);
      end
      if (m_have) begin
        check("out_res", bus.out_res, m_res);
        check("out_rd", bus.out_rd, m_rd);
        check("out_err", bus.out_err, m_err);
      end
    end
  end

  // Responder configuration: selected unit, ack delay, spurious ack, re-ack after req falls.
  int           r_unit = 0, r_delay = 1000, r_spur_at = 0;
  bit           r_spur = 1'b0, r_reack = 1'b0;
  logic [W-1:0] r_val = '0, r_spur_val = '0, r_reack_val = '0;
  int           rsp_cnt;
  bit           rsp_prev, rsp_pend;
  logic [N-1:0]   rsp_ack;
  logic [N*W-1:0] rsp_res;

  // Unit responder: counts req-high cycles of r_unit and drives acks just after each edge.
  initial begin
    bus.unit_ack = '0; bus.unit_res = '0;
    rsp_cnt = 0; rsp_prev = 1'b0; rsp_pend = 1'b0; rsp_res = '0;
    forever begin
      @(posedge clk); #1;
      rsp_ack = '0;
      if (rsp_pend) begin
        rsp_ack[0] = 1'b1; rsp_res[0 +: W] = r_reack_val; rsp_pend = 1'b0;
      end
      if (bus.unit_req[r_unit]) begin
        rsp_cnt++;
        if (rsp_cnt == r_delay + 1) begin
          rsp_ack[r_unit] = 1'b1; rsp_res[r_unit*W +: W] = r_val;
        end
        if (r_spur && rsp_cnt == r_spur_at) begin
          rsp_ack[1] = 1'b1; rsp_res[W +: W] = r_spur_val;
        end
      end else begin
        if (rsp_prev && r_reack) rsp_pend = 1'b1;
        rsp_cnt = 0;
      end
      rsp_prev = bus.unit_req[r_unit];
      bus.unit_ack = rsp_ack;
      bus.unit_res = rsp_res;
    end
  end

  task automatic do_op(input logic [2:0] unit, input logic [1:0] op,
                       input logic [W-1:0] s1, input logic [W-1:0] s2, input logic [4:0] rd);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1; bus.in_unit = unit; bus.in_op = op;
    bus.in_src1 = s1; bus.in_src2 = s2; bus.in_rd = rd;
    for (int i = 0; i < 40; i++) begin
      if (bus.in_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!done) check("accept_wait", 64'd0, 64'd1);
  endtask

  task automatic wait_result(output int reqc, output int edges, output int irdy);
    bit got;
    got = 1'b0; reqc = 0; edges = 0; irdy = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
      if (bus.unit_req != '0) reqc++;
      if (bus.in_ready) irdy++;
      @(posedge clk); #1;
      edges++;
    end
    if (!got) check("result_wait", 64'd0, 64'd1);
  endtask

  int reqc, edges, irdy;

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_unit = '0; bus.in_op = '0;
    bus.in_src1 = '0; bus.in_src2 = '0; bus.in_rd = '0; bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_unit_req", bus.unit_req, 64'd0);
    check("rst_unit_op", bus.unit_op, 64'd0);
    check("rst_unit_src1", bus.unit_src1, 64'd0);
    check("rst_unit_src2", bus.unit_src2, 64'd0);
    check("rst_out_valid", bus.out_valid, 64'd0);
    check("rst_out_res", bus.out_res, 64'd0);
    check("rst_out_rd", bus.out_rd, 64'd0);
    check("rst_out_err", bus.out_err, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    check("rel_in_ready", bus.in_ready, 64'd1);

    // Unit 0 with a one-cycle ack.
    bus.out_ready = 1'b1;
    r_unit = 0; r_delay = 1; r_val = 32'hBF800000;
    do_op(3'd0, 2'b00, 32'h3F800000, 32'hBF800000, 5'd7);
    wait_result(reqc, edges, irdy);
    check("t1_res", bus.out_res, 64'hBF800000);
    check("t1_rd", bus.out_rd, 64'd7);
    check("t1_err", bus.out_err, 64'd0);
    check("t1_req_cycles", reqc, 64'd2);
    check("t1_latency", edges, 64'd2);
    @(posedge clk); #1;
    check("t1_in_ready_after", bus.in_ready, 64'd1);

    // Invalid unit index: an error result appears the cycle after accept, with no request.
    do_op(3'd5, 2'b01, 32'h1234, 32'h5678, 5'd9);
    wait_result(reqc, edges, irdy);
    check("t3_req_cycles", reqc, 64'd0);
    check("t3_latency", edges, 64'd0);
    check("t3_err", bus.out_err, 64'd1);
    check("t3_res", bus.out_res, 64'd0);
    check("t3_rd", bus.out_rd, 64'd9);

    // Unit 2 acks late while unit 1 acks spuriously.
    r_unit = 2; r_delay = 7; r_val = 32'h40490FDB;
    r_spur = 1'b1; r_spur_at = 3; r_spur_val = 32'h11111111;
    do_op(3'd2, 2'b10, 32'hAAAA0000, 32'h0000BBBB, 5'd19);
    wait_result(reqc, edges, irdy);
    r_spur = 1'b0;
    check("t2_res", bus.out_res, 64'h40490FDB);
    check("t2_err", bus.out_err, 64'd0);
    check("t2_req_cycles", reqc, 64'd8);
    check("t2_in_ready_low", irdy, 64'd0);

    // Writeback stalls for 10 cycles while unit 0 re-acks with a new value.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    r_unit = 0; r_delay = 1; r_val = 32'h12345678;
    r_reack = 1'b1; r_reack_val = 32'hDEADBEEF;
    do_op(3'd0, 2'b11, 32'h12345678, 32'h0, 5'd31);
    wait_result(reqc, edges, irdy);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    r_reack = 1'b0;
    check("t4_res_held", bus.out_res, 64'h12345678);
    check("t4_valid_held", bus.out_valid, 64'd1);
    check("t4_in_ready_low", bus.in_ready, 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_valid_drop", bus.out_valid, 64'd0);
    check("t4_in_ready_back", bus.in_ready, 64'd1);

    // Reset pulse in WAIT abandons the op. The following op completes normally.
    r_unit = 3; r_delay = 1000;
    do_op(3'd3, 2'b01, 32'h5, 32'h6, 5'd3);
    @(posedge clk); @(posedge clk); #1;
    check("t5_req_before", bus.unit_req, 64'h8);
    rst = 1'b1;
    #1;
    check("t5_async_req", bus.unit_req, 64'd0);
    check("t5_async_valid", bus.out_valid, 64'd0);
    check("t5_async_err", bus.out_err, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("t5_in_ready_rel", bus.in_ready, 64'd1);
    r_delay = 2; r_val = 32'hC0000000;
    do_op(3'd3, 2'b10, 32'h7, 32'h8, 5'd12);
    wait_result(reqc, edges, irdy);
    check("t5_res", bus.out_res, 64'hC0000000);
    check("t5_rd", bus.out_rd, 64'd12);
    check("t5_err", bus.out_err, 64'd0);
    @(posedge clk); #1;

`ifdef ECLIPTIC_FPU_DISPATCH_TIMEOUT_EN
    // No ack: the watchdog ends WAIT after TMO cycles.
    r_unit = 1; r_delay = 1000;
    do_op(3'd1, 2'b00, 32'h9, 32'hA, 5'd21);
    wait_result(reqc, edges, irdy);
    check("t6_req_cycles", reqc, 64'd16);
    check("t6_err", bus.out_err, 64'd1);
    check("t6_res", bus.out_res, 64'd0);
    @(posedge clk); #1;
`endif

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
